// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  localparam int   STATE_W          = 3;
  localparam int   CLKS_PER_BIT_DEF = 4;
  localparam logic IDLE_LEVEL       = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int               CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // bit_done must not depend on clear: clear is derived from the state change bit_done causes.
  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends each as a UART frame (start, data LSB-first, stop).
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              r_en,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               bit_done;
  logic               baud_clear;
`ifdef PARITY_EN
  logic               par_q, par_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    frame_cnt_d = frame_cnt_q;
`ifdef PARITY_EN
    par_d       = par_q;
`endif
    r_en        = 1'b0;
    busy        = 1'b1;
    tx          = IDLE_LEVEL;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (tx_en && !empty) state_d = REQ;
      end
      REQ: begin
        r_en    = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        // The FIFO registered its output on the REQ edge, so it is valid now.
        shift_d = fifo_data;
        bit_d   = '0;
`ifdef PARITY_EN
        par_d   = ^fifo_data;
`endif
        state_d = START;
      end
      START: begin
        tx = ~IDLE_LEVEL;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        tx = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
`ifdef PARITY_EN
          if (bit_q == LAST_BIT) state_d = PARITY;
`else
          if (bit_q == LAST_BIT) state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef PARITY_EN
        tx = par_q;
        if (bit_done) state_d = STOP;
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (bit_done) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign baud_clear = (state_d != state_q);
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      frame_cnt_q <= '0;
`ifdef PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule
